// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial WIDTH-bit adder, one sum bit per clock, LSB first.
// Revision: 1.0
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sr_next;

  // Full-adder cell on the current LSBs and the held carry.
  assign w_s = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
  always_comb begin
    w_sr_next            = r_sr >> 1;
    w_sr_next[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sr    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_sum   <= w_sr_next;
            r_cout  <= w_c;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Directed, table-driven bench for serial_adder at WIDTH=8 and 1.
// Revision: 1.0
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       c8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       co8;

  logic       s1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       c1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       co1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(co8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(co1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected {cout,sum} captured on every accepted start.
  logic [8:0] exp8;
  logic       pend8 = 1'b0;
  logic       prev_done8 = 1'b0;
  logic [1:0] exp1;
  logic       pend1 = 1'b0;
  logic       prev_done1 = 1'b0;

  always @(posedge clk) begin
    if (rst) pend8 <= 1'b0;
    else if (s8 && !busy8) begin
      exp8  <= {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      pend8 <= 1'b1;
    end else if (done8) pend8 <= 1'b0;
    if (rst) pend1 <= 1'b0;
    else if (s1 && !busy1) begin
      exp1  <= {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
      pend1 <= 1'b1;
    end else if (done1) pend1 <= 1'b0;
  end

  always @(negedge clk) begin
    if (done8) begin
      check("sb8_pending", {31'd0, pend8}, 32'd1);
      check("sb8_result", {23'd0, co8, sum8}, {23'd0, exp8});
      check("sb8_done_width", {31'd0, prev_done8}, 32'd0);
      check("sb8_busy_with_done", {31'd0, busy8}, 32'd0);
    end
    if (done1) begin
      check("sb1_pending", {31'd0, pend1}, 32'd1);
      check("sb1_result", {30'd0, co1, sum1}, {30'd0, exp1});
      check("sb1_done_width", {31'd0, prev_done1}, 32'd0);
      check("sb1_busy_with_done", {31'd0, busy1}, 32'd0);
    end
    prev_done8 <= done8;
    prev_done1 <= done1;
  end

  // Called at the negedge just after the start edge; returns negedges until done.
  task automatic wait_done8(input string nm, output int n);
    int bad;
    n = 0;
    bad = 0;
    while (!done8 && n < 40) begin
      if (!busy8) bad++;
      @(negedge clk);
      n++;
    end
    check({nm, "_busy_in_shift"}, bad, 0);
  endtask

  task automatic add8(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] es, input logic ec);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; c8 = c; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    wait_done8(nm, n);
    check({nm, "_latency"}, n, 8);
    check({nm, "_sum"}, {24'd0, sum8}, {24'd0, es});
    check({nm, "_cout"}, {31'd0, co8}, {31'd0, ec});
  endtask

  task automatic add1(input string nm, input logic a, input logic b, input logic c,
                      input logic es, input logic ec);
    int n;
    @(negedge clk);
    a1 = a; b1 = b; c1 = c; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    n = 0;
    while (!done1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, 1);
    check({nm, "_sum_cout"}, {30'd0, co1, sum1}, {30'd0, ec, es});
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic co;
  } vec1_t;

  vec8_t v8[7];
  vec1_t v1[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;

    v8[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    v8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    v8[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    v8[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    v8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    v8[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    v8[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    v1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    v1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    v1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    v1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; s8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    s1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy8", {31'd0, busy8}, 32'd0);
    check("reset_done8", {31'd0, done8}, 32'd0);
    check("reset_sum_cout8", {23'd0, co8, sum8}, 32'd0);
    check("reset_state1", {28'd0, busy1, done1, co1, sum1}, 32'd0);

    for (int i = 0; i < 7; i++)
      add8($sformatf("vec8_%0d", i), v8[i].a, v8[i].b, v8[i].cin, v8[i].s, v8[i].co);

    // Back-to-back: second start issued during the DONE cycle.
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b1; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    wait_done8("b2b_first", n);
    check("b2b_first_sum_cout", {23'd0, co8, sum8}, 32'h100);
    a8 = 8'h3C; b8 = 8'h42; c8 = 1'b0; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    check("b2b_accepted_busy", {31'd0, busy8}, 32'd1);
    repeat (4) @(negedge clk);
    check("b2b_sum_hold", {23'd0, co8, sum8}, 32'h100);
    wait_done8("b2b_second", n);
    check("b2b_second_latency", n + 4, 8);
    check("b2b_second_sum_cout", {23'd0, co8, sum8}, 32'h07E);

    // Start during SHIFT must be ignored.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    wait_done8("ignore", n);
    check("ignore_latency", n + 3, 8);
    check("ignore_sum_cout", {23'd0, co8, sum8}, 32'h046);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    check("ignore_no_second_done", cnt, 0);

    // Reset mid-add aborts with no done.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy8}, 32'd0);
    check("abort_done", {31'd0, done8}, 32'd0);
    check("abort_sum_cout", {23'd0, co8, sum8}, 32'd0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) cnt++;
    end
    check("abort_stays_idle", cnt, 0);
    add8("after_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    for (int i = 0; i < 8; i++)
      add1($sformatf("vec1_%0d", i), v1[i].a, v1[i].b, v1[i].cin, v1[i].s, v1[i].co);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
